// File: rtl/axi_port_arbiter_pkg.sv
// Shared types and constants for the multi-port AXI arbiter.
package axi_port_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [15:0] REMAP_FROM     = 16'hbfaf;
  localparam logic [15:0] REMAP_TO       = 16'h1faf;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  // Kseg1-style alias of the boot window onto its physical region.
  function automatic logic [15:0] remap_hi(input logic [15:0] hi);
    return (hi == REMAP_FROM) ? REMAP_TO : hi;
  endfunction

endpackage

// File: rtl/axi_port_arbiter_if.sv
// AXI4 ar/r/aw/w/b bundle with master and slave views.
interface axi_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;

  logic              rvalid, rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;

  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_port_arbiter_port_arbiter.sv
// Combinational grant: first requesting port at or after ptr, wrapping.
module port_arbiter #(
  parameter int NPORT = 2,
  parameter int IDX_W = 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);
  int j;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int i = 0; i < NPORT; i++) begin
      j = int'(ptr) + i;
      if (j >= NPORT) j = j - NPORT;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/axi_port_arbiter.sv
// Multi-port to single AXI master arbiter, one transaction outstanding.
// Define ARB_RR_EN for round-robin arbitration (default: fixed priority).
module axi_port_arbiter
  import axi_port_arbiter_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NPORT-1:0]           req_valid,
  input  logic [NPORT-1:0]           req_write,
  input  logic [NPORT*ADDR_W-1:0]    req_addr,
  input  logic [NPORT*2-1:0]         req_size,
  input  logic [NPORT*DATA_W/8-1:0]  req_wstrb,
  input  logic [NPORT*DATA_W-1:0]    req_wdata,
  input  logic [NPORT-1:0]           req_flush,
  output logic [NPORT-1:0]           resp_ready,
  output logic [DATA_W-1:0]          resp_rdata,
  axi_port_arbiter_if.master         m
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [NPORT-1:0]    resp_ready_q, resp_ready_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                cancel_q, cancel_d;

  logic [IDX_W-1:0]    ptr, gnt_idx;
  logic                gnt_any, flush_g;
  int                  gi;

`ifdef ARB_RR_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  port_arbiter #(.NPORT(NPORT), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid & ~req_flush),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign flush_g = req_flush[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_ready_d = '0;
    resp_rdata_d = resp_rdata_q;
    cancel_d     = cancel_q | flush_g;
    gi           = int'(gnt_idx);
`ifdef ARB_RR_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (gnt_any) begin
          grant_d         = gnt_idx;
          addr_d          = req_addr[gi*ADDR_W +: ADDR_W];
          addr_d[31:16]   = remap_hi(addr_d[31:16]);
          size_d          = req_size[gi*2 +: 2];
          wstrb_d         = req_wstrb[gi*STRB_W +: STRB_W];
          wdata_d         = req_wdata[gi*DATA_W +: DATA_W];
`ifdef ARB_RR_EN
          ptr_d = (gi == NPORT-1) ? '0 : gnt_idx + 1'b1;
`endif
          if (req_write[gi]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end
        end
      end
      S_AR: if (m.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_R;
      end
      // Completion cycle stays in R/B so the requester sees resp_ready and
      // drops req_valid before the next IDLE arbitration.
      S_R: begin
        if (rready_q) begin
          if (m.rvalid) begin
            rready_d              = 1'b0;
            resp_rdata_d          = m.rdata;
            resp_ready_d[grant_q] = !(cancel_q || flush_g);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (awvalid_q && m.awready) awvalid_d = 1'b0;
        if (wvalid_q && m.wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m.awready) && (!wvalid_q || m.wready)) begin
          bready_d = 1'b1;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (bready_q) begin
          if (m.bvalid) begin
            bready_d              = 1'b0;
            resp_ready_d[grant_q] = !(cancel_q || flush_g);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_ready_q <= '0;
      resp_rdata_q <= '0;
      cancel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_ready_q <= resp_ready_d;
      resp_rdata_q <= resp_rdata_d;
      cancel_q     <= cancel_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  assign resp_ready = resp_ready_q;
  assign resp_rdata = resp_rdata_q;

  assign m.arvalid = arvalid_q;
  assign m.arid    = ID_W'(grant_q);
  assign m.araddr  = addr_q;
  assign m.arlen   = 8'd0;
  assign m.arsize  = {1'b0, size_q};
  assign m.arburst = AXI_BURST_INCR;
  assign m.arlock  = 1'b0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.rready  = rready_q;

  assign m.awvalid = awvalid_q;
  assign m.awid    = ID_W'(grant_q);
  assign m.awaddr  = addr_q;
  assign m.awlen   = 8'd0;
  assign m.awsize  = {1'b0, size_q};
  assign m.awburst = AXI_BURST_INCR;
  assign m.awlock  = 1'b0;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.wvalid  = wvalid_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wlast   = 1'b1;
  assign m.bready  = bready_q;

  logic unused_axi;
  assign unused_axi = &{1'b0, m.rid, m.rresp, m.rlast, m.bid, m.bresp};
endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed bench for axi_port_arbiter; expectations track the ARB_RR_EN build.
module tb_axi_port_arbiter;
  import axi_port_arbiter_pkg::*;

  localparam int NPORT  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic                      aclk = 1'b0;
  logic                      aresetn;
  logic [NPORT-1:0]          req_valid, req_write, req_flush;
  logic [NPORT*ADDR_W-1:0]   req_addr;
  logic [NPORT*2-1:0]        req_size;
  logic [NPORT*DATA_W/8-1:0] req_wstrb;
  logic [NPORT*DATA_W-1:0]   req_wdata;
  logic [NPORT-1:0]          resp_ready;
  logic [DATA_W-1:0]         resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  axi_port_arbiter #(.NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wstrb  (req_wstrb),
    .req_wdata  (req_wdata),
    .req_flush  (req_flush),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .m          (axi.master)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read from IDLE with arready already high; rvalid one cycle after AR.
  task automatic do_read(input int id, input logic [31:0] data, input logic [1:0] next_req);
    tick;
    chk("arb_arvalid", 64'(axi.arvalid), 64'd1);
    chk("arb_arid", 64'(axi.arid), 64'(id));
    tick;
    chk("arb_rready", 64'(axi.rready), 64'd1);
    axi.rvalid = 1'b1;
    axi.rdata  = data;
    tick;
    chk("arb_resp", 64'(resp_ready), 64'd1 << id);
    chk("arb_rdata", 64'(resp_rdata), 64'(data));
    axi.rvalid = 1'b0;
    req_valid  = next_req;
    tick;
  endtask

  initial begin
    aresetn = 1'b0;
    req_valid = '0; req_write = '0; req_flush = '0;
    req_addr = '0; req_size = '0; req_wstrb = '0; req_wdata = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rid = '0;
    axi.rresp = '0; axi.rlast = 1'b1; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    tick; tick;
    chk("rst_state", 64'(dut.state_q), 64'(S_IDLE));
    chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi.wvalid), 64'd0);
    chk("rst_rready", 64'(axi.rready), 64'd0);
    chk("rst_bready", 64'(axi.bready), 64'd0);
    chk("rst_resp", 64'(resp_ready), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    aresetn = 1'b1;
    tick;

    // Single read from port 0
    req_addr[0 +: ADDR_W] = 32'h1fc00000;
    req_size[0 +: 2]      = SZ_WORD;
    req_valid             = 2'b01;
    axi.arready           = 1'b1;
    tick;
    chk("rd_arvalid", 64'(axi.arvalid), 64'd1);
    chk("rd_araddr", 64'(axi.araddr), 64'h1fc00000);
    chk("rd_arid", 64'(axi.arid), 64'd0);
    chk("rd_arsize", 64'(axi.arsize), 64'd2);
    chk("rd_arlen", 64'(axi.arlen), 64'd0);
    chk("rd_arburst", 64'(axi.arburst), 64'd1);
    tick;
    chk("rd_ar_drop", 64'(axi.arvalid), 64'd0);
    chk("rd_rready", 64'(axi.rready), 64'd1);
    chk("rd_no_early_resp", 64'(resp_ready), 64'd0);
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h3c1d0001;
    tick;
    chk("rd_resp_lat3", 64'(resp_ready), 64'b01);
    chk("rd_rdata", 64'(resp_rdata), 64'h3c1d0001);
    chk("rd_rready_off", 64'(axi.rready), 64'd0);
    axi.rvalid = 1'b0;
    req_valid  = 2'b00;
    tick;
    chk("rd_resp_pulse", 64'(resp_ready), 64'd0);
    chk("rd_idle", 64'(dut.state_q), 64'(S_IDLE));

    // Write from port 1, AW then W two cycles later, with address remap
    req_addr[ADDR_W +: ADDR_W]  = 32'hbfaf8000;
    req_write                   = 2'b10;
    req_size[2 +: 2]            = SZ_HALF;
    req_wstrb[4 +: 4]           = 4'b0011;
    req_wdata[DATA_W +: DATA_W] = 32'h0000beef;
    req_valid                   = 2'b10;
    axi.arready                 = 1'b0;
    axi.awready                 = 1'b1;
    tick;
    chk("wr_awvalid", 64'(axi.awvalid), 64'd1);
    chk("wr_wvalid", 64'(axi.wvalid), 64'd1);
    chk("wr_awaddr_remap", 64'(axi.awaddr), 64'h1faf8000);
    chk("wr_awid", 64'(axi.awid), 64'd1);
    chk("wr_wstrb", 64'(axi.wstrb), 64'b0011);
    chk("wr_wdata", 64'(axi.wdata), 64'h0000beef);
    chk("wr_wlast", 64'(axi.wlast), 64'd1);
    chk("wr_no_ar", 64'(axi.arvalid), 64'd0);
    tick;
    axi.awready = 1'b0;
    chk("wr_aw_drop", 64'(axi.awvalid), 64'd0);
    chk("wr_w_hold", 64'(axi.wvalid), 64'd1);
    tick;
    chk("wr_w_hold2", 64'(axi.wvalid), 64'd1);
    axi.wready = 1'b1;
    tick;
    axi.wready = 1'b0;
    chk("wr_w_drop", 64'(axi.wvalid), 64'd0);
    chk("wr_bready", 64'(axi.bready), 64'd1);
    chk("wr_no_resp", 64'(resp_ready), 64'd0);
    axi.bvalid = 1'b1;
    tick;
    axi.bvalid = 1'b0;
    chk("wr_resp", 64'(resp_ready), 64'b10);
    chk("wr_bready_off", 64'(axi.bready), 64'd0);
    req_valid = 2'b00;
    req_write = 2'b00;
    tick;
    chk("wr_idle", 64'(dut.state_q), 64'(S_IDLE));

    // Simultaneous reads from ports 0 and 1
    req_addr[0 +: ADDR_W]      = 32'h00000100;
    req_addr[ADDR_W +: ADDR_W] = 32'h00000200;
    axi.arready = 1'b1;
    req_valid   = 2'b11;
`ifdef ARB_RR_EN
    do_read(0, 32'h11111111, 2'b11);
    do_read(1, 32'h22222222, 2'b01);
    do_read(0, 32'h33333333, 2'b00);
`else
    do_read(0, 32'h11111111, 2'b11);
    do_read(0, 32'h22222222, 2'b10);
    do_read(1, 32'h33333333, 2'b00);
`endif
    chk("arb_idle", 64'(dut.state_q), 64'(S_IDLE));

    // Flush mid-read on port 1
    req_valid = 2'b10;
    tick;
    chk("fl_arid", 64'(axi.arid), 64'd1);
    tick;
    chk("fl_in_r", 64'(dut.state_q), 64'(S_R));
    req_flush = 2'b10;
    tick;
    chk("fl_rready_held", 64'(axi.rready), 64'd1);
    axi.rvalid = 1'b1;
    axi.rdata  = 32'hdeadbeef;
    tick;
    axi.rvalid = 1'b0;
    chk("fl_no_resp", 64'(resp_ready), 64'd0);
    chk("fl_rready_done", 64'(axi.rready), 64'd0);
    req_valid = 2'b00;
    req_flush = 2'b00;
    tick;
    chk("fl_no_resp2", 64'(resp_ready), 64'd0);
    chk("fl_idle", 64'(dut.state_q), 64'(S_IDLE));

    // Flushed port is not granted from IDLE
    req_valid = 2'b01;
    req_flush = 2'b01;
    tick;
    chk("fl_idle_nogrant", 64'(axi.arvalid), 64'd0);
    chk("fl_idle_state", 64'(dut.state_q), 64'(S_IDLE));
    req_valid = 2'b00;
    req_flush = 2'b00;
    axi.arready = 1'b0;

    // Reset in the middle of a write
    req_addr[0 +: ADDR_W] = 32'h00001000;
    req_write = 2'b01;
    req_valid = 2'b01;
    tick;
    chk("rw_awvalid", 64'(axi.awvalid), 64'd1);
    chk("rw_awaddr", 64'(axi.awaddr), 64'h00001000);
    aresetn = 1'b0;
    tick;
    chk("rw_awvalid_rst", 64'(axi.awvalid), 64'd0);
    chk("rw_wvalid_rst", 64'(axi.wvalid), 64'd0);
    chk("rw_state_rst", 64'(dut.state_q), 64'(S_IDLE));
    chk("rw_resp_rst", 64'(resp_ready), 64'd0);
    aresetn   = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    tick;
    chk("rw_resp_after", 64'(resp_ready), 64'd0);
    chk("rw_idle_after", 64'(dut.state_q), 64'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
